// File: rtl/char_stream_source_pkg.sv
// char_stream_pkg: shared state encoding, terminator default and ASCII codes for the character stream source.
package char_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_TERM
   } state_t;

   localparam int TERM_DEFAULT = 0;

   localparam logic [7:0] SPACE     = 8'd32;
   localparam logic [7:0] BACKSLASH = 8'd92;
   localparam logic [7:0] DOT       = 8'd46;
   localparam logic [7:0] EQUALS    = 8'd61;

endpackage

// File: rtl/char_stream_source_if.sv
// char_stream_source_if: load/control/stream signals between a controller and the character stream source.
interface char_stream_source_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
);

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              wr_clear;
   logic              start;
   logic              repeat_mode;
   logic              abort;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              data_ready;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   length;
   logic              write_err;

   modport master (
      output wr_en, wr_data, wr_clear, start, repeat_mode, abort, data_ready,
      input  data_out, data_valid, busy, done, length, write_err
   );

   modport slave (
      input  wr_en, wr_data, wr_clear, start, repeat_mode, abort, data_ready,
      output data_out, data_valid, busy, done, length, write_err
   );

endinterface

// File: rtl/char_stream_source_char_buffer.sv
// char_buffer: DEPTH x DATA_W storage, one write port and one synchronous read port, unreset so it maps to block RAM.
module char_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data_q <= mem[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/char_stream_source.sv
// char_stream_source: streams a loaded character buffer over valid/ready, then one terminator word; finishes or repeats.
module char_stream_source
   import char_stream_pkg::*;
#(
   parameter int                DATA_W = 8,
   parameter int                DEPTH  = 64,
   parameter int                ADDR_W = $clog2(DEPTH),
   parameter logic [DATA_W-1:0] TERM   = DATA_W'(TERM_DEFAULT)
) (
   input logic clk_25mhz,
   input logic reset_n,
   char_stream_source_if.slave bus
);

   localparam logic [ADDR_W:0]   FULL     = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              done_q, done_d;
   logic              werr_q, werr_d;
   logic [DATA_W-1:0] rd_data;
   logic              xfer, last, wr_ok;

   assign xfer  = state_q != ST_IDLE && bus.data_ready;
   assign last  = {1'b0, idx_q} == len_q - LEN_ONE;
   assign wr_ok = state_q == ST_IDLE && bus.wr_en && !bus.wr_clear && !bus.start && len_q != FULL;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      done_d  = 1'b0;
      werr_d  = bus.wr_en && (state_q != ST_IDLE || bus.start || (!bus.wr_clear && len_q == FULL));
      if (state_q == ST_IDLE) begin
         if (bus.start) begin
            state_d = len_q == '0 ? ST_TERM : ST_STREAM;
            idx_d   = '0;
         end else if (bus.wr_clear) begin
            len_d = '0;
         end else if (wr_ok) begin
            len_d = len_q + LEN_ONE;
         end
      end else if (bus.abort) begin
         state_d = ST_IDLE;
         idx_d   = '0;
      end else if (xfer) begin
         if (state_q == ST_STREAM) begin
            state_d = last ? ST_TERM : ST_STREAM;
            idx_d   = last ? '0 : idx_q + IDX_ONE;
         end else if (bus.repeat_mode) begin
            state_d = len_q == '0 ? ST_TERM : ST_STREAM;
            idx_d   = '0;
         end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_25mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         done_q  <= 1'b0;
         werr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         done_q  <= done_d;
         werr_q  <= werr_d;
      end
   end

   // Reading at idx_d lets the next byte appear right after a transfer and re-reads the same byte during a stall.
   char_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_buf (
      .clk     (clk_25mhz),
      .wr_en   (wr_ok),
      .wr_addr (len_q[ADDR_W-1:0]),
      .wr_data (bus.wr_data),
      .rd_addr (idx_d),
      .rd_data (rd_data)
   );

   assign bus.data_out   = state_q == ST_STREAM ? rd_data : TERM;
   assign bus.data_valid = state_q != ST_IDLE;
   assign bus.busy       = state_q != ST_IDLE;
   assign bus.done       = done_q;
   assign bus.length     = len_q;
   assign bus.write_err  = werr_q;

endmodule

// File: tb/tb_char_stream_source.sv
// tb_char_stream_source: directed checks of loading, streaming, back-pressure, overflow, repeat, abort and reset.
module tb_char_stream_source;
   import char_stream_pkg::*;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   logic [7:0] prog [8];
   logic [7:0] rep  [3];
   logic [7:0] abcd [4];
   logic [7:0] got  [9];
   logic [7:0] hold_d;
   logic [31:0] pat;
   int   n;
   logic stall;

   char_stream_source_if #(.DATA_W(8), .DEPTH(64)) a ();
   char_stream_source_if #(.DATA_W(8), .DEPTH(4))  b ();

   char_stream_source #(.DATA_W(8), .DEPTH(64)) u_a (
      .clk_25mhz (clk),
      .reset_n   (reset_n),
      .bus       (a)
   );

   char_stream_source #(.DATA_W(8), .DEPTH(4)) u_b (
      .clk_25mhz (clk),
      .reset_n   (reset_n),
      .bus       (b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr_a(input logic [7:0] c);
      a.wr_en   = 1'b1;
      a.wr_data = c;
      @(negedge clk);
      a.wr_en   = 1'b0;
   endtask

   task automatic clear_a();
      a.wr_clear = 1'b1;
      @(negedge clk);
      a.wr_clear = 1'b0;
   endtask

   task automatic start_a();
      a.start = 1'b1;
      @(negedge clk);
      a.start = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      prog = '{SPACE, 8'd105, 8'd100, EQUALS, BACKSLASH, 8'd120, DOT, 8'd120};
      rep  = '{8'h78, 8'h79, 8'h00};
      abcd = '{8'h61, 8'h62, 8'h63, 8'h64};
      reset_n = 1'b0;
      {a.wr_en, a.wr_clear, a.start, a.repeat_mode, a.abort, a.data_ready} = '0;
      {b.wr_en, b.wr_clear, b.start, b.repeat_mode, b.abort, b.data_ready} = '0;
      a.wr_data = '0;
      b.wr_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_valid", a.data_valid, 0);
      chk("rst_busy", a.busy, 0);
      chk("rst_done", a.done, 0);
      chk("rst_werr", a.write_err, 0);
      chk("rst_len", a.length, 0);
      chk("rst_data", a.data_out, 0);
      chk("rst_b_len", b.length, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Full-throughput stream with ready held high
      a.data_ready = 1'b1;
      for (int i = 0; i < 8; i++) wr_a(prog[i]);
      chk("load_len", a.length, 8);
      start_a();
      for (int i = 0; i < 8; i++) begin
         chk("s1_valid", a.data_valid, 1);
         chk("s1_data", a.data_out, prog[i]);
         @(negedge clk);
      end
      chk("s1_term_valid", a.data_valid, 1);
      chk("s1_term_data", a.data_out, 0);
      @(negedge clk);
      chk("s1_done", a.done, 1);
      chk("s1_valid_off", a.data_valid, 0);
      chk("s1_busy_off", a.busy, 0);
      @(negedge clk);
      chk("s1_done_pulse", a.done, 0);
      chk("s1_len_kept", a.length, 8);

      // Back-pressure with a fixed irregular ready pattern
      n = 0;
      stall = 1'b0;
      hold_d = '0;
      pat = 32'hB2E5_93A7;
      start_a();
      for (int c = 0; c < 100 && !a.done; c++) begin
         if (stall) chk("s2_hold", a.data_out, hold_d);
         a.data_ready = pat[c % 32];
         if (a.data_valid && a.data_ready && n < 9) begin
            got[n] = a.data_out;
            n++;
         end
         stall  = a.data_valid && !a.data_ready;
         hold_d = a.data_out;
         @(negedge clk);
      end
      chk("s2_done", a.done, 1);
      chk("s2_count", n, 9);
      for (int i = 0; i < 8; i++) chk("s2_data", got[i], prog[i]);
      chk("s2_term", got[8], 0);
      a.data_ready = 1'b1;
      @(negedge clk);

      // Overflow on the 4-deep instance
      b.data_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b.wr_en   = 1'b1;
         b.wr_data = abcd[i];
         @(negedge clk);
         chk("b_fill_err", b.write_err, 0);
      end
      b.wr_data = 8'h65;
      @(negedge clk);
      chk("b_ovf_err", b.write_err, 1);
      chk("b_ovf_len", b.length, 4);
      b.wr_en = 1'b0;
      @(negedge clk);
      chk("b_err_pulse", b.write_err, 0);
      b.start = 1'b1;
      @(negedge clk);
      b.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("b_valid", b.data_valid, 1);
         chk("b_data", b.data_out, abcd[i]);
         @(negedge clk);
      end
      chk("b_term_valid", b.data_valid, 1);
      chk("b_term_data", b.data_out, 0);
      @(negedge clk);
      chk("b_done", b.done, 1);

      // Empty buffer: a lone terminator then done
      clear_a();
      chk("e_len", a.length, 0);
      start_a();
      chk("e_valid", a.data_valid, 1);
      chk("e_data", a.data_out, 0);
      chk("e_busy", a.busy, 1);
      @(negedge clk);
      chk("e_done", a.done, 1);
      chk("e_valid_off", a.data_valid, 0);

      // Repeat mode, then drop repeat to end after the next terminator
      wr_a(8'h78);
      wr_a(8'h79);
      a.repeat_mode = 1'b1;
      start_a();
      for (int i = 0; i < 6; i++) begin
         chk("r_valid", a.data_valid, 1);
         chk("r_data", a.data_out, rep[i % 3]);
         @(negedge clk);
      end
      a.repeat_mode = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("r_end_valid", a.data_valid, 1);
         chk("r_end_data", a.data_out, rep[i]);
         @(negedge clk);
      end
      chk("r_done", a.done, 1);
      chk("r_valid_off", a.data_valid, 0);

      // Abort mid-stream and immediate replay
      clear_a();
      for (int i = 0; i < 8; i++) wr_a(prog[i]);
      start_a();
      for (int i = 0; i < 3; i++) begin
         chk("ab_data", a.data_out, prog[i]);
         if (i == 2) a.abort = 1'b1;
         @(negedge clk);
      end
      a.abort = 1'b0;
      chk("ab_valid", a.data_valid, 0);
      chk("ab_busy", a.busy, 0);
      chk("ab_done", a.done, 0);
      chk("ab_dout", a.data_out, 0);
      chk("ab_len", a.length, 8);
      start_a();
      chk("ab_re_valid", a.data_valid, 1);
      chk("ab_re_b0", a.data_out, prog[0]);
      @(negedge clk);
      chk("ab_re_b1", a.data_out, prog[1]);

      // Asynchronous reset mid-stream
      #2 reset_n = 1'b0;
      #1;
      chk("ar_valid", a.data_valid, 0);
      chk("ar_busy", a.busy, 0);
      chk("ar_len", a.length, 0);
      chk("ar_dout", a.data_out, 0);
      chk("ar_done", a.done, 0);
      chk("ar_werr", a.write_err, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("ar_idle", a.busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/char_stream_source.md
Name: char_stream_source

Overview:
- Synthesizable, parametrised successor to the fixed-string stimulus driver that feeds the lambda-calculus model one character per clock.
- Holds a loadable character buffer and streams it to a consumer (e.g. the model's data_in) over a valid/ready handshake.
- After the last character it emits one terminator word, then finishes or repeats.
- Used both on-board (UART-loaded programs) and in benches, replacing hand-written assign tables.

Parameters:
- DATA_W, 8, character width in bits.
- DEPTH, 64, buffer capacity in characters.
- ADDR_W, $clog2(DEPTH), buffer index width.
- TERM, 0, terminator word emitted after the last character and driven while idle.

Ports:
- clk_25mhz  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- wr_en  in  1  append wr_data to the buffer.
- wr_data  in  DATA_W  character to append.
- wr_clear  in  1  set length to 0.
- start  in  1  single-cycle pulse; begin streaming.
- repeat_mode  in  1  restart from index 0 after the terminator; sampled when the terminator is accepted.
- abort  in  1  stop streaming immediately.
- data_out  out  DATA_W  current character.
- data_valid  out  1  data_out is valid.
- data_ready  in  1  consumer accepts data_out this cycle.
- busy  out  1  not in IDLE.
- done  out  1  one-cycle pulse when a non-repeating stream completes.
- length  out  ADDR_W+1  number of characters loaded, 0..DEPTH.
- write_err  out  1  one-cycle pulse for a rejected write.

Behaviour:
- Reset values: data_out=TERM, data_valid=0, busy=0, done=0, write_err=0, length=0, state=IDLE, idx=0. Buffer contents are not reset.
- A transfer occurs in any cycle where data_valid && data_ready.
- While data_valid && !data_ready, data_out and data_valid must hold stable.
- State IDLE:
  - wr_clear has priority over wr_en: length<=0.
  - Otherwise wr_en with length<DEPTH writes buf[length] and increments length.
  - wr_en with length==DEPTH: write dropped, write_err pulses.
  - start:
    - if length>0, go to STREAM, idx<=0.
    - if length==0, go to TERM.
  - start and wr_en in the same cycle: start wins, write dropped, write_err pulses.
- State STREAM:
  - Synchronous buffer read; data_valid rises the cycle after entry, i.e. byte 0 is valid at cycle t+1 after start at t.
  - On each transfer, advance idx. The next byte is presented with no bubble: the read address is the next index whenever a transfer occurs, giving full throughput of one char/cycle under constant ready.
  - On the transfer of index length-1, go to TERM.
- State TERM:
  - Present data_out=TERM, data_valid=1.
  - On transfer with repeat_mode=1: go to STREAM at idx 0, or stay in TERM if length==0. Byte 0 follows with no bubble.
  - On transfer with repeat_mode=0: go to IDLE, data_valid<=0, done pulses for one cycle.
- Writes, wr_clear and start while busy: ignored. A write while busy pulses write_err; length is frozen while busy.
- abort (any non-IDLE state): IDLE next cycle, data_valid<=0, data_out<=TERM, no done pulse. abort has priority over a transfer in the same cycle; that transfer counts as taken by the consumer. The buffer and length are retained.
- Outside STREAM/TERM, data_out=TERM.
- reset_n asserted mid-stream: immediate return to reset values; length resets to 0.
- idx never exceeds length-1 and does not wrap into unloaded entries.

Decomposition:
- Package char_stream_pkg:
  - state enum {IDLE, STREAM, TERM}
  - default TERM constant
  - ASCII constants used by benches (SPACE=32, BACKSLASH=92, DOT=46, EQUALS=61)
- Sub-module char_buffer: DEPTH x DATA_W, one write port, one synchronous read port, no reset. It maps to block RAM.
- The FSM, index, length and handshake logic live in the top.

Test Plan:
- Load " id=\x.x" (32,105,100,61,92,120,46,120); start with ready tied high.
  - Expected: those 8 bytes on consecutive cycles from t+1, then 0 for one cycle.
  - Then done pulses; data_valid is 0 afterwards; length stays 8.
- Same load, ready toggled pseudo-randomly.
  - Expected: the sequence is unchanged and complete.
  - data_out never changes while valid && !ready.
- Fill DEPTH=4 with 'a','b','c','d', then write 'e'.
  - Expected: write_err pulses, length=4.
  - A stream outputs a,b,c,d,0.
- length=0, start.
  - Expected: a single 0 word with valid=1, then done.
  - No buffer read is observed.
- Load "xy", repeat_mode=1, ready high.
  - Expected: x,y,0,x,y,0,... with no bubbles.
  - Deassert repeat_mode: the stream ends after the next 0 and done pulses.
- Mid-stream abort, then reset_n low mid-stream.
  - abort: valid=0 next cycle, no done; an immediate restart replays from byte 0.
  - reset_n low: all outputs return to reset values asynchronously, length=0.
